cdc_fifo_stream_reader: RTL and testbench

// - Read-domain consumer for the CDC FIFO read port (show-ahead: read_data valid while !empty, pop on read_increment).
// - Turns the pop interface into a registered valid/ready output stream through a 2-entry skid buffer.
// - No combinational path from out_ready to fifo_read_increment.
// - Adds enable/flush control and an accepted-word counter. Sits between the FIFO read side and read-domain logic.

---
 rtl/cdc_fifo_stream_reader_if.sv | 28 ++
 rtl/cdc_fifo_stream_reader.sv | 55 +++++
 tb/tb_cdc_fifo_stream_reader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cdc_fifo_stream_reader_if.sv
// cdc_fifo_stream_reader_if: FIFO read port, output stream and control/status bundle of the stream reader
//   fifo_read_data/fifo_empty/fifo_read_increment : show-ahead FIFO read port (pop on increment)
//   enable/flush                                  : run permission level and 1-cycle flush request
//   out_data/out_valid/out_ready                  : registered valid/ready output stream
//   word_count/busy                               : saturating transfer count, flush-in-progress flag
interface cdc_fifo_stream_reader_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]  fifo_read_data;
  logic                   fifo_empty;
  logic                   fifo_read_increment;
  logic                   enable;
  logic                   flush;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [COUNT_WIDTH-1:0] word_count;
  logic                   busy;
  modport master (
    input  fifo_read_data, fifo_empty, enable, flush, out_ready,
    output fifo_read_increment, out_data, out_valid, word_count, busy
  );
  modport slave (
    output fifo_read_data, fifo_empty, enable, flush, out_ready,
    input  fifo_read_increment, out_data, out_valid, word_count, busy
  );
endinterface

// File: rtl/cdc_fifo_stream_reader.sv
// cdc_fifo_stream_reader: pops a show-ahead CDC FIFO into a 2-entry skid buffer feeding a valid/ready stream
//   clock : read-domain clock
//   reset : asynchronous active-high reset
//   bus   : master side of cdc_fifo_stream_reader_if (FIFO read port, stream, enable/flush, count/busy)
module cdc_fifo_stream_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  cdc_fifo_stream_reader_if.master  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t                 state_q, state_d;
  logic [1:0]             occ_q, occ_d;
  logic [DATA_WIDTH-1:0]  head_q, head_d, skid_q, skid_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   pop, push, xfer, flush_req;
  // Pop decision uses only registered occupancy, so out_ready never reaches the FIFO strobe combinationally.
  always_comb begin
    pop       = !bus.fifo_empty && (state_q == FLUSH || (state_q == RUN && occ_q != 2'd2));
    push      = pop && state_q == RUN;
    xfer      = occ_q != 2'd0 && bus.out_ready;
    flush_req = bus.flush && state_q != FLUSH;
    state_d   = flush_req ? FLUSH :
                state_q == FLUSH ? (bus.fifo_empty ? IDLE : FLUSH) :
                bus.enable ? RUN : IDLE;
    occ_d     = flush_req ? 2'd0 : occ_q + {1'b0, push} - {1'b0, xfer};
    // New word lands in head when the buffer is (or is becoming) empty, otherwise in skid.
    head_d    = (push && (occ_q == 2'd0 || (occ_q == 2'd1 && xfer))) ? bus.fifo_read_data :
                xfer ? skid_q : head_q;
    skid_d    = (push && occ_q == 2'd1 && !xfer) ? bus.fifo_read_data : skid_q;
    count_d   = (xfer && !(&count_q)) ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      occ_q   <= '0;
      head_q  <= '0;
      skid_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      count_q <= count_d;
    end
  end
  assign bus.fifo_read_increment = pop;
  assign bus.out_data            = head_q;
  assign bus.out_valid           = occ_q != 2'd0;
  assign bus.word_count          = count_q;
  assign bus.busy                = state_q == FLUSH;
endmodule

// File: tb/tb_cdc_fifo_stream_reader.sv
// tb_cdc_fifo_stream_reader: directed stimulus with a per-cycle reference model of the stream reader
module tb_cdc_fifo_stream_reader;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en4 = 1'b0;
  always #5 clock = ~clock;
  cdc_fifo_stream_reader_if #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) bus ();
  cdc_fifo_stream_reader_if #(.DATA_WIDTH(8), .COUNT_WIDTH(4))  bus4 ();
  cdc_fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (.clock(clock), .reset(reset), .bus(bus));
  cdc_fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(4))  dut4 (.clock(clock), .reset(reset), .bus(bus4));
  logic [7:0] mem [256];
  logic [7:0] wr = 8'd0;
  logic [7:0] rd = 8'd0;
  assign bus.fifo_empty     = rd == wr;
  assign bus.fifo_read_data = mem[rd];
  always @(posedge clock) if (bus.fifo_read_increment) rd <= rd + 8'd1;
  assign bus4.fifo_empty     = !en4;
  assign bus4.fifo_read_data = 8'h5A;
  assign bus4.enable         = en4;
  assign bus4.flush          = 1'b0;
  assign bus4.out_ready      = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  int         st_m = 0;
  int         cnt_m = 0;
  int         n_pop = 0;
  logic [7:0] sb[$];
  logic [7:0] lg[$];
  logic       ep, xf, pu;
  always @(negedge clock) begin
    if (reset) begin
      st_m = 0;
      cnt_m = 0;
      sb.delete();
      check("rst_pop", bus.fifo_read_increment, 0);
    end else begin
      ep = !bus.fifo_empty && (st_m == 2 || (st_m == 1 && sb.size() < 2));
      check("pop", bus.fifo_read_increment, ep);
      check("valid", bus.out_valid, sb.size() != 0);
      check("busy", bus.busy, st_m == 2);
      check("count", bus.word_count, cnt_m);
      if (sb.size() != 0) check("data", bus.out_data, sb[0]);
      xf = sb.size() != 0 && bus.out_ready;
      pu = ep && st_m == 1;
      if (ep) n_pop++;
      if (xf) begin
        lg.push_back(sb.pop_front());
        if (cnt_m < 65535) cnt_m++;
      end
      if (pu) sb.push_back(bus.fifo_read_data);
      if (bus.flush && st_m != 2) begin
        sb.delete();
        st_m = 2;
      end else if (st_m == 2) st_m = bus.fifo_empty ? 0 : 2;
      else st_m = bus.enable ? 1 : 0;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic put(input logic [7:0] w);
    mem[wr] = w;
    wr = wr + 8'd1;
  endtask
  int         p0, b, c0;
  logic [7:0] ex [100];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.enable = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    tick(2);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_count", bus.word_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_inc", bus.fifo_read_increment, 0);
    check("rst_count4", bus4.word_count, 0);
    reset = 1'b0;
    tick(1);
    put(8'hA0); put(8'hA1); put(8'hA2);
    bus.out_ready = 1'b1;
    bus.enable = 1'b1;
    p0 = n_pop;
    tick(6);
    check("t1_pops", n_pop - p0, 3);
    check("t1_count", bus.word_count, 3);
    check("t1_nout", lg.size(), 3);
    for (int i = 0; i < 3; i++) check("t1_word", lg[i], 8'hA0 + i);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) put(8'hB0 + 8'(i));
    p0 = n_pop;
    tick(6);
    check("t2_pops", n_pop - p0, 2);
    check("t2_inc", bus.fifo_read_increment, 0);
    check("t2_hold", bus.out_data, 8'hB0);
    check("t2_valid", bus.out_valid, 1);
    b = lg.size();
    bus.out_ready = 1'b1;
    tick(8);
    check("t2_nout", lg.size() - b, 5);
    for (int i = 0; i < 5; i++) check("t2_word", lg[b + i], 8'hB0 + i);
    b = lg.size();
    c0 = int'(bus.word_count);
    for (int i = 0; i < 100; i++) begin
      ex[i] = 8'($urandom_range(0, 255));
      put(ex[i]);
    end
    for (int i = 0; i < 250; i++) begin
      bus.out_ready = (i % 2) == 0;
      tick(1);
    end
    bus.out_ready = 1'b1;
    tick(5);
    check("t3_nout", lg.size() - b, 100);
    check("t3_count", bus.word_count, c0 + 100);
    for (int i = 0; i < 100; i++) check("t3_word", lg[b + i], ex[i]);
    bus.out_ready = 1'b0;
    put(8'hC0); put(8'hC1);
    tick(4);
    check("t4_valid", bus.out_valid, 1);
    p0 = n_pop;
    put(8'hD0); put(8'hD1); put(8'hD2);
    tick(2);
    check("t4_nopop", n_pop - p0, 0);
    p0 = n_pop;
    c0 = int'(bus.word_count);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    check("t4_drop", bus.out_valid, 0);
    check("t4_busy", bus.busy, 1);
    tick(8);
    check("t4_pops", n_pop - p0, 3);
    check("t4_idle", bus.busy, 0);
    check("t4_count", bus.word_count, c0);
    check("t4_empty", bus.fifo_empty, 1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(8'hE0 + 8'(i));
    tick(4);
    p0 = n_pop;
    bus.enable = 1'b0;
    tick(4);
    check("t5_nopop", n_pop - p0, 0);
    b = lg.size();
    bus.out_ready = 1'b1;
    tick(4);
    check("t5_nout", lg.size() - b, 2);
    check("t5_w0", lg[b], 8'hE0);
    check("t5_w1", lg[b + 1], 8'hE1);
    check("t5_valid", bus.out_valid, 0);
    bus.enable = 1'b1;
    tick(6);
    check("t5_drain", bus.fifo_empty, 1);
    for (int i = 0; i < 4; i++) put(8'hF0 + 8'(i));
    tick(3);
    check("t6_pre_valid", bus.out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid", bus.out_valid, 0);
    check("t6_count", bus.word_count, 0);
    check("t6_inc", bus.fifo_read_increment, 0);
    tick(2);
    reset = 1'b0;
    tick(6);
    en4 = 1'b1;
    tick(25);
    check("t7_sat", bus4.word_count, 15);
    en4 = 1'b0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
